// File: rtl/cnn_pkg.sv
// Shared definitions for the 3x3 convolution datapath.
//   - Image/pixel/coefficient/accumulator widths and image row pitch.
//   - FSM state type of the window MAC.
//   - win_offset(): row-major 3x3 tap offset for a given row pitch.
package cnn_pkg;

  localparam int unsigned PIX_W     = 8;
  localparam int unsigned COEF_W    = 8;
  localparam int unsigned ACC_W     = 20;
  localparam int unsigned IMG_WIDTH = 80;
  localparam int unsigned ADDR_W    = 13;
  localparam int unsigned NumTaps   = 9;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StOut
  } state_e;

  // Tap k of a 3x3 window: row k/3, column k%3.
  function automatic int unsigned win_offset(input int unsigned k, input int unsigned width);
    return (k / 3) * width + (k % 3);
  endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// Registered signed x unsigned multiply-accumulate.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   clr_i         : zero the accumulator (wins over en_i)
//   en_i          : add pix_i * coef_i into the accumulator
//   pix_i         : unsigned pixel
//   coef_i        : signed coefficient
//   acc_o         : registered accumulator
//   acc_next_o    : acc_o plus the current product, for a same-edge capture downstream
module conv_mac_unit #(
  parameter int unsigned PixW  = 8,
  parameter int unsigned CoefW = 8,
  parameter int unsigned AccW  = 20
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic        [PixW-1:0]  pix_i,
  input  logic signed [CoefW-1:0] coef_i,
  output logic signed [AccW-1:0]  acc_o,
  output logic signed [AccW-1:0]  acc_next_o
);

  localparam int unsigned ProdW = PixW + CoefW + 1;

  logic signed [ProdW-1:0] prod;
  logic signed [AccW-1:0]  acc_q, acc_d;

  always_comb begin
    // Zero-extend the pixel so it multiplies as a non-negative signed value.
    prod       = $signed({1'b0, pix_i}) * coef_i;
    acc_next_o = acc_q + {{(AccW - ProdW){prod[ProdW-1]}}, prod};
    acc_d      = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_next_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/conv3x3_window_mac.sv
// 3x3 convolution window fetch + MAC.
// Accepts a window top-left address, reads the 9 pixels from a single-port synchronous
// memory (one read per cycle, data one cycle later), accumulates them against a latched
// signed kernel and presents the result with a valid/ready handshake.
//   clk, rst_n                   : clock, synchronous active-low reset
//   base_addr/valid/ready        : window request handshake
//   coef                         : 9 signed taps, row-major, k0 in the LSBs
//   mem_addr, mem_rd_en, mem_data: image memory read port
//   out_data/valid/ready         : result handshake
module conv3x3_window_mac #(
  parameter int unsigned WIDTH  = cnn_pkg::IMG_WIDTH,
  parameter int unsigned ADDR_W = cnn_pkg::ADDR_W,
  parameter int unsigned PIX_W  = cnn_pkg::PIX_W,
  parameter int unsigned COEF_W = cnn_pkg::COEF_W,
  parameter int unsigned ACC_W  = cnn_pkg::ACC_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic                  base_valid,
  output logic                  base_ready,
  input  logic [9*COEF_W-1:0]   coef,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_rd_en,
  input  logic [PIX_W-1:0]      mem_data,
  output logic [ACC_W-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  import cnn_pkg::*;

  state_e                    state_q, state_d;
  logic        [3:0]         k_q, k_d;
  logic        [ADDR_W-1:0]  base_q, base_d;
  logic signed [COEF_W-1:0]  coef_q [NumTaps];
  logic signed [COEF_W-1:0]  coef_d [NumTaps];
  logic        [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic                      mem_rd_en_q, mem_rd_en_d;
  logic signed [ACC_W-1:0]   out_data_q, out_data_d;
  // Read issued last cycle and its tap index: the data arriving now belongs to it.
  logic                      acc_en_q;
  logic        [3:0]         acc_k_q;

  logic                      acc_clr;
  logic signed [COEF_W-1:0]  coef_sel;
  logic signed [ACC_W-1:0]   acc_val, acc_next;

  always_comb begin
    coef_sel = '0;
    for (int i = 0; i < int'(NumTaps); i++) begin
      if (acc_k_q == 4'(i)) begin
        coef_sel = coef_q[i];
      end
    end
  end

  conv_mac_unit #(
    .PixW  (PIX_W),
    .CoefW (COEF_W),
    .AccW  (ACC_W)
  ) u_mac (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clr_i      (acc_clr),
    .en_i       (acc_en_q),
    .pix_i      (mem_data),
    .coef_i     (coef_sel),
    .acc_o      (acc_val),
    .acc_next_o (acc_next)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    base_d      = base_q;
    coef_d      = coef_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_en_d = 1'b0;
    out_data_d  = out_data_q;
    acc_clr     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (base_valid) begin
          base_d = base_addr;
          for (int i = 0; i < int'(NumTaps); i++) begin
            coef_d[i] = coef[i*COEF_W +: COEF_W];
          end
          acc_clr     = 1'b1;
          k_d         = 4'd0;
          mem_addr_d  = base_addr;
          mem_rd_en_d = 1'b1;
          state_d     = StFetch;
        end
      end
      StFetch: begin
        if (k_q == 4'd8) begin
          state_d = StDrain;
        end else begin
          k_d         = k_q + 4'd1;
          mem_addr_d  = base_q + ADDR_W'(win_offset(int'(k_q) + 1, WIDTH));
          mem_rd_en_d = 1'b1;
        end
      end
      StDrain: begin
        // Tap 8 data is on mem_data now; capture the sum including it.
        out_data_d = acc_next;
        state_d    = StOut;
      end
      StOut: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      k_q         <= '0;
      base_q      <= '0;
      for (int i = 0; i < int'(NumTaps); i++) begin
        coef_q[i] <= '0;
      end
      mem_addr_q  <= '0;
      mem_rd_en_q <= 1'b0;
      out_data_q  <= '0;
      acc_en_q    <= 1'b0;
      acc_k_q     <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      base_q      <= base_d;
      coef_q      <= coef_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_en_q <= mem_rd_en_d;
      out_data_q  <= out_data_d;
      acc_en_q    <= mem_rd_en_q;
      acc_k_q     <= k_q;
    end
  end

  assign base_ready = (state_q == StIdle);
  assign out_valid  = (state_q == StOut);
  assign out_data   = out_data_q;
  assign mem_addr   = mem_addr_q;
  assign mem_rd_en  = mem_rd_en_q;

  // Accumulator value is only observed through acc_next; keep it visible for debug.
  logic unused_acc;
  assign unused_acc = ^acc_val;

endmodule

// File: tb/tb_conv3x3_window_mac.sv
module tb_conv3x3_window_mac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] base_addr;
  logic        base_valid;
  logic        base_ready;
  logic [71:0] coef;
  logic [12:0] mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_data;
  logic [19:0] out_data;
  logic        out_valid;
  logic        out_ready;

  conv3x3_window_mac dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .base_addr  (base_addr),
    .base_valid (base_valid),
    .base_ready (base_ready),
    .coef       (coef),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_data   (mem_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Image memory: synchronous read, data valid the cycle after the address.
  logic [7:0] mem [8192];
  always @(posedge clk) if (mem_rd_en) mem_data <= mem[mem_addr];

  longint      exp_q[$];
  logic [12:0] addr_exp_q[$];
  logic [12:0] obs_q[$];
  always @(negedge clk) if (rst_n === 1'b1 && mem_rd_en === 1'b1) obs_q.push_back(mem_addr);

  typedef struct {
    string       name;
    bit          fill_ff;
    logic [12:0] base;
    logic [71:0] coef;
    longint      expv;
  } vec_t;

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input bit ff);
    for (int a = 0; a < 8192; a++) mem[a] = ff ? 8'hff : 8'(a);
  endtask

  function automatic logic [71:0] all_coef(input logic [7:0] v);
    return {9{v}};
  endfunction

  function automatic logic [12:0] tap_addr(input logic [12:0] b, input int k);
    return 13'(int'(b) + (k / 3) * 80 + (k % 3));
  endfunction

  function automatic longint model(input logic [12:0] b, input logic [71:0] c);
    longint s = 0;
    logic [71:0] cc = c;
    for (int k = 0; k < 9; k++) begin
      logic signed [7:0] ck = cc[k*8 +: 8];
      s += longint'(mem[tap_addr(b, k)]) * longint'(ck);
    end
    return s;
  endfunction

  task automatic send_window(input logic [12:0] b, input logic [71:0] c, input longint expv,
                             input bit push, output int a_cyc);
    int n = 0;
    base_addr  = b;
    coef       = c;
    base_valid = 1'b1;
    @(negedge clk);
    while (!base_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!base_ready) check("accept_timeout", 0, 1);
    a_cyc = cyc;
    if (push) begin
      exp_q.push_back(expv);
      for (int k = 0; k < 9; k++) addr_exp_q.push_back(tap_addr(b, k));
    end
    tick();
    base_valid = 1'b0;
  endtask

  task automatic check_addrs();
    check("rd_count", obs_q.size(), 9);
    while (obs_q.size() > 0 && addr_exp_q.size() > 0)
      check("mem_addr", obs_q.pop_front(), addr_exp_q.pop_front());
    obs_q.delete();
    addr_exp_q.delete();
  endtask

  // Waits for out_valid, checks latency/data, completes the output handshake.
  task automatic wait_result(input int a_cyc, input bit chk_lat);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      check("out_timeout", 0, 1);
      return;
    end
    if (chk_lat) check("latency", cyc - a_cyc, 11);
    if (exp_q.size() == 0) check("scoreboard_empty", 0, 1);
    else check("out_data", longint'($signed(out_data)), exp_q.pop_front());
    n = 0;
    while (!out_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    tick();
    check_addrs();
  endtask

  vec_t vecs[6];

  initial begin
    int a, a2, n;
    logic [19:0] held;
    bit saw_valid;

    vecs[0] = '{"identity", 1'b0, 13'd0, 72'(1) << 32, 81};
    vecs[1] = '{"min_coef", 1'b1, 13'd0, all_coef(8'h80), -293760};
    vecs[2] = '{"max_coef", 1'b1, 13'd37, all_coef(8'h7f), 291465};
    vecs[3] = '{"sum_ones", 1'b0, 13'd100, all_coef(8'h01), 861};
    vecs[4] = '{"neg_tap8", 1'b0, 13'd10, 72'(8'hfd) << 64, -516};
    vecs[5] = '{"tap0_tap8", 1'b0, 13'd8000, (72'(1) << 64) | 72'(2), 354};

    // Reset with a request pending: nothing is accepted.
    rst_n = 1'b0; base_valid = 1'b1; base_addr = 13'd5; coef = '0; out_ready = 1'b1;
    tick(); tick();
    check("rst_base_ready", base_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_rd_en", mem_rd_en, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1; base_valid = 1'b0;
    tick();
    check("post_rst_rd_en", mem_rd_en, 0);
    check("post_rst_ready", base_ready, 1);

    foreach (vecs[i]) begin
      fill(vecs[i].fill_ff);
      send_window(vecs[i].base, vecs[i].coef, vecs[i].expv, 1'b1, a);
      wait_result(a, 1'b1);
    end
    fill(1'b0);

    // Throughput: back-to-back windows 12 cycles apart.
    send_window(13'd500, all_coef(8'h02), model(13'd500, all_coef(8'h02)), 1'b1, a);
    wait_result(a, 1'b1);
    send_window(13'd600, all_coef(8'hff), model(13'd600, all_coef(8'hff)), 1'b1, a2);
    check("throughput", a2 - a, 12);
    wait_result(a2, 1'b1);

    // Backpressure: held output, no reads, new request ignored until release.
    out_ready = 1'b0;
    send_window(13'd50, all_coef(8'h01), model(13'd50, all_coef(8'h01)), 1'b1, a);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_latency", cyc - a, 11);
    held = out_data;
    base_addr = 13'd300; base_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, held);
      check("bp_base_ready", base_ready, 0);
      check("bp_rd_en", mem_rd_en, 0);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    if (exp_q.size() > 0) check("bp_result", longint'($signed(out_data)), exp_q.pop_front());
    else check("scoreboard_empty", 0, 1);
    check_addrs();
    tick();
    a = cyc;
    check("bp_release_ready", base_ready, 1);
    exp_q.push_back(model(13'd300, all_coef(8'h01)));
    for (int k = 0; k < 9; k++) addr_exp_q.push_back(tap_addr(13'd300, k));
    tick();
    base_valid = 1'b0;
    check("bp_next_rd_en", mem_rd_en, 1);
    check("bp_next_addr", mem_addr, 300);
    wait_result(a, 1'b1);

    // Reset during FETCH at tap 4 aborts the window.
    send_window(13'd400, all_coef(8'h01), 0, 1'b0, a);
    tick(); tick(); tick(); tick();
    check("abort_k4_addr", mem_addr, 481);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_ready", base_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_rd_en", mem_rd_en, 0);
    saw_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
      tick();
    end
    check("abort_no_output", saw_valid, 0);
    obs_q.delete();

    // Address wrap at the top of memory.
    send_window(13'd8190, 72'(1) << 32, 79, 1'b1, a);
    wait_result(a, 1'b1);

    // Kernel is latched at acceptance.
    send_window(13'd200, all_coef(8'h01), model(13'd200, all_coef(8'h01)), 1'b1, a);
    tick();
    coef = '0;
    wait_result(a, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/conv3x3_window_mac.md
# conv3x3_window_mac

Consumer stage for the window-address generator. Accepts one top-left window address per handshake, fetches the 3×3 pixel neighbourhood from the single-port synchronous image memory, and multiply-accumulates it against a 3×3 signed kernel. It emits one signed convolution result per window with a valid/ready handshake toward the activation/output stage.

## Interface
- `WIDTH`, 80: image row pitch in pixels; sets the row offsets.
- `ADDR_W`, 13: image memory address width.
- `PIX_W`, 8: pixel width, unsigned.
- `COEF_W`, 8: kernel coefficient width, signed two's complement.
- `ACC_W`, 20: accumulator and result width, signed.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `base_addr`, in, ADDR_W: window top-left address, taken from the address generator.
- `base_valid`, in, 1: `base_addr` is valid.
- `base_ready`, out, 1: block can accept a window.
- `coef`, in, 9*COEF_W: kernel, row-major; k0 sits in the LSBs.
- `mem_addr`, out, ADDR_W: image memory read address, registered.
- `mem_rd_en`, out, 1: read strobe.
- `mem_data`, in, PIX_W: read data, one cycle after `mem_addr`/`mem_rd_en`.
- `out_data`, out, ACC_W: convolution result, signed.
- `out_valid`, out, 1: `out_data` is valid.
- `out_ready`, in, 1: downstream accepts the result.

## Operation
- The FSM has four states: IDLE, FETCH, DRAIN, OUT.
- IDLE:
  - `base_ready` = 1.
  - On `base_valid && base_ready`, latch `base_addr` and all of `coef`, clear the accumulator, set k=0, then go to FETCH.
- FETCH:
  - One read per cycle for k=0..8, with `mem_addr = base + off(k)` and `mem_rd_en` = 1.
  - Offsets: 0, 1, 2, W, W+1, W+2, 2W, 2W+1, 2W+2.
  - After k=8 is issued, go to DRAIN.
- Accumulate:
  - In every cycle following an issued read k, add `acc += $signed({1'b0,mem_data}) * coef_latched[k]`.
  - Each product is 17-bit signed, sign-extended to ACC_W.
- DRAIN: adds product k=8, loads `out_data` ← final acc, then goes to OUT.
- OUT:
  - `out_valid` = 1 and `out_data` is held stable until `out_valid && out_ready`, then go to IDLE.
  - No new window is accepted in OUT.
- Arithmetic:
  - Worst-case |sum| is 9·255·128 = 293760 < 2^19, so 20 bits never overflow. No saturation or shift.
  - Address sum is modulo 2^ADDR_W; wrap is silent and is not checked.
- `coef` and `base_addr` changes after acceptance have no effect on the window in flight.
- `base_valid` outside IDLE is ignored, because `base_ready` = 0.

## Timing
- Reset (`rst_n` = 0 at a clock edge) gives:
  - state IDLE, `base_ready` = 1, `out_valid` = 0, `out_data` = 0, `mem_addr` = 0, `mem_rd_en` = 0, acc = 0.
- Reset mid-operation aborts the window. No `out_valid` is produced for it.
- Latency, with the handshake at cycle A:
  - FETCH runs in cycles A+1..A+9.
  - DRAIN is in A+10.
  - `out_valid` rises in A+11.
- Throughput: one window per 12 cycles with `out_ready` held high (the OUT→IDLE cycle plus the handshake).
- `base_ready` is a registered state decode. It falls the cycle after acceptance.
- Backpressure holds the block in OUT indefinitely. `mem_rd_en` = 0 throughout.

## Structure
- Shared package `cnn_pkg` holds:
  - `PIX_W`, `COEF_W`, `ACC_W`, `IMG_WIDTH`, `ADDR_W`;
  - the FSM state enum type;
  - a function `win_offset(k, width)` returning the row-major 3×3 offset.
- One natural sub-module, `conv_mac_unit`:
  - a registered signed×unsigned multiply-add with a clear input;
  - the top level keeps the FSM, k counter, address adder and output register.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with `base_valid`=1.
  - Required: `base_ready`=1, `out_valid`=0, `mem_addr`=0, `mem_rd_en`=0; no window is accepted during reset.
- **Identity kernel:** memory[a]=a[7:0]; `coef` centre=1, all others 0; base=0.
  - Required `mem_addr` sequence: 0, 1, 2, 80, 81, 82, 160, 161, 162.
  - Required: `out_data`=81 with `out_valid` at A+11.
- **Extreme values:** all pixels=255, all coefficients=-128.
  - Required: `out_data`=-293760 with no overflow.
  - Repeat with coefficients=+127: `out_data`=291465.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in OUT, with `base_valid`=1 and a new `base_addr`.
  - Required: `out_data` and `out_valid` are stable, `base_ready`=0, and no reads are issued.
  - Next window is accepted one cycle after `out_ready` rises.
- **Reset and wrap:** assert `rst_n`=0 during FETCH at k=4.
  - Required next cycle: IDLE, with no `out_valid`.
  - Then run base=8190: addresses 8190, 8191, 0, 78, 79, 80, 158, 159, 160.
- **Coefficient stability:** change `coef` from all-1 to all-0 at A+3.
  - Required: result equals the sum of the 9 pixels, i.e. the latched kernel is used.
